// File: rtl/serial_sub_nbit.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int RW = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, nxt;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [RW-1:0]    res;
    logic             br;
    logic             a, b, d, br_n, last, accept;

    assign a      = a_sr[0];
    assign b      = b_sr[0];
    assign d      = a ^ b ^ br;
    assign br_n   = (~a & b) | (~(a ^ b) & br);
    assign last   = (count == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = SHIFT;
            SHIFT:   if (last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Low bits of the result accumulate in res; the final bit goes straight to Diff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            br    <= 1'b0;
            count <= '0;
            Diff  <= '0;
            Bout  <= 1'b0;
        end else if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= Bin;
            count <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            br    <= br_n;
            res   <= (res >> 1) | (RW'(d) << (RW - 1));
            count <= count + 1'b1;
            if (last) begin
                Diff <= {d, res};
                Bout <= br_n;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
        end else if (state == SHIFT && last) begin
            Ovf <= (a_msb ^ b_msb) & (a_msb ^ d);
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Scoreboard bench for serial_sub_nbit (WIDTH=4).
// Overflow checks run when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_nbit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         Bin;
    logic [W-1:0] Diff;
    logic         Bout, busy, done;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    serial_sub_nbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Diff  (Diff),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic bin, input int acc);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (a[W-1] ^ b[W-1]) & (a[W-1] ^ full[W-1]);
        e.acc  = acc;
        return e;
    endfunction

    // Output monitor: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done) begin
            last_done = cyc;
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", 32'(Diff), 32'(e.diff));
                chk("bout", 32'(Bout), 32'(e.bout));
                chk("latency", 32'(cyc - e.acc), 32'(W));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", 32'(Ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy || q.size() != 0) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin);
        wait_idle();
        @(negedge clk);
        A = a;
        B = b;
        Bin = bin;
        start = 1'b1;
        q.push_back(model(a, b, bin, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int t1;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_diff", 32'(Diff), 32'd0);
        chk("rst_bout", 32'(Bout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        launch(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_idle();

        launch(4'd3, 4'd9, 1'b0);
        launch(4'd0, 4'd0, 1'b1);
        launch(4'hF, 4'h0, 1'b1);
        launch(4'h0, 4'hF, 1'b1);
        wait_idle();

        // start and operand churn during SHIFT must be ignored
        launch(4'd5, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1;
            A = (i == 0) ? 4'hF : W'($urandom);
            B = (i == 0) ? 4'h0 : W'($urandom);
            Bin = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);

        // reset in the second SHIFT cycle aborts the op
        launch(4'hC, 4'h4, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("abort_diff", 32'(Diff), 32'd0);
        chk("abort_bout", 32'(Bout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        launch(4'hC, 4'h4, 1'b0);
        wait_idle();

        // back-to-back: restart in the first IDLE cycle after done
        launch(4'd7, 4'd2, 1'b1);
        t1 = 0;
        for (int n = 0; n < 20 && !done; n++) @(negedge clk);
        if (!done) chk("b2b_timeout1", 32'd0, 32'd1);
        t1 = cyc;
        A = 4'd2;
        B = 4'd6;
        Bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        q.push_back(model(4'd2, 4'd6, 1'b0, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("b2b_gap", 32'(last_done - t1), 32'(W + 2));

`ifdef SERIAL_SUB_OVF_EN
        launch(4'd8, 4'd1, 1'b0);
        launch(4'd7, 4'hF, 1'b0);
        launch(4'd5, 4'd3, 1'b0);
        wait_idle();
`endif

        for (int i = 0; i < 12; i++)
            launch(W'($urandom), W'($urandom), 1'($urandom));
        wait_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
